// File: rtl/axi_arbiter.sv
// axi_arbiter: shares one AXI4-Lite style memory port between an instruction
// fetch unit (read only) and a load/store unit (read and write). Exactly one
// transaction is outstanding on the memory side at any time. Writes have
// priority over reads. Read contention is resolved round-robin. Data and
// response fields pass through combinationally. Request/grant steering adds
// one IDLE cycle before every transaction.
module axi_arbiter (
    input  logic        clk,
    input  logic        rst,

    // IFU read address / read data
    input  logic [31:0] ifu_araddr,
    input  logic        ifu_arvalid,
    output logic        ifu_arready,
    output logic [31:0] ifu_rdata,
    output logic        ifu_rresp,
    output logic        ifu_rvalid,
    input  logic        ifu_rready,

    // LSU read address / read data
    input  logic [31:0] lsu_araddr,
    input  logic        lsu_arvalid,
    output logic        lsu_arready,
    output logic [31:0] lsu_rdata,
    output logic        lsu_rresp,
    output logic        lsu_rvalid,
    input  logic        lsu_rready,

    // LSU write address / write data / write response
    input  logic [31:0] lsu_awaddr,
    input  logic        lsu_awvalid,
    output logic        lsu_awready,
    input  logic [31:0] lsu_wdata,
    input  logic [3:0]  lsu_wstrb,
    input  logic        lsu_wvalid,
    output logic        lsu_wready,
    output logic        lsu_bresp,
    output logic        lsu_bvalid,
    input  logic        lsu_bready,

    // Memory side, all five channels
    output logic [31:0] mem_araddr,
    output logic        mem_arvalid,
    input  logic        mem_arready,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rresp,
    input  logic        mem_rvalid,
    output logic        mem_rready,
    output logic [31:0] mem_awaddr,
    output logic        mem_awvalid,
    input  logic        mem_awready,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    output logic        mem_wvalid,
    input  logic        mem_wready,
    input  logic        mem_bresp,
    input  logic        mem_bvalid,
    output logic        mem_bready
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD_IFU = 2'd1,
        RD_LSU = 2'd2,
        WR_LSU = 2'd3
    } state_t;

    state_t state_reg, state_next;

    // Per-transaction "already handshaken" flags; they keep an accepted
    // address/data beat from being presented to memory a second time.
    logic ar_done_reg, ar_done_next;
    logic aw_done_reg, aw_done_next;
    logic w_done_reg,  w_done_next;

    // Round-robin pointer: 1 means the LSU wins the next read contention.
    logic rr_lsu_reg, rr_lsu_next;

    // Read masters packed into index form: 0 = IFU, 1 = LSU.
    logic [31:0] m_araddr [2];
    logic [1:0]  m_arvalid;
    logic [1:0]  m_rready;
    logic [1:0]  m_arready;
    logic [1:0]  m_rvalid;

    logic rd_active;
    logic rd_sel;
    logic wr_active;

    logic ar_fire;
    logic r_fire;
    logic aw_fire;
    logic w_fire;
    logic b_fire;

    assign m_araddr[0] = ifu_araddr;
    assign m_araddr[1] = lsu_araddr;
    assign m_arvalid   = {lsu_arvalid, ifu_arvalid};
    assign m_rready    = {lsu_rready, ifu_rready};

    assign rd_active = (state_reg == RD_IFU) || (state_reg == RD_LSU);
    assign rd_sel    = (state_reg == RD_LSU);
    assign wr_active = (state_reg == WR_LSU);

    // State, handshake flags and round-robin pointer registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= IDLE;
            ar_done_reg <= 1'b0;
            aw_done_reg <= 1'b0;
            w_done_reg  <= 1'b0;
            rr_lsu_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            ar_done_reg <= ar_done_next;
            aw_done_reg <= aw_done_next;
            w_done_reg  <= w_done_next;
            rr_lsu_reg  <= rr_lsu_next;
        end
    end

    // Read path: steer the granted master's AR/R channel onto memory.
    always_comb begin
        mem_araddr  = m_araddr[rd_sel];
        mem_arvalid = rd_active && m_arvalid[rd_sel] && !ar_done_reg;
        mem_rready  = rd_active && m_rready[rd_sel];
    end

    // Each read master only sees ready/valid while it owns the memory port.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd_master
            localparam logic SEL = 1'(gi);
            assign m_arready[gi] = rd_active && (rd_sel == SEL) && mem_arready && !ar_done_reg;
            assign m_rvalid[gi]  = rd_active && (rd_sel == SEL) && mem_rvalid;
        end
    endgenerate

    assign ifu_arready = m_arready[0];
    assign lsu_arready = m_arready[1];
    assign ifu_rvalid  = m_rvalid[0];
    assign lsu_rvalid  = m_rvalid[1];

    // Read data and response fields pass straight through with no latency.
    assign ifu_rdata = mem_rdata;
    assign lsu_rdata = mem_rdata;
    assign ifu_rresp = mem_rresp;
    assign lsu_rresp = mem_rresp;

    // Write path: AW, W and B routed between LSU and memory during WR_LSU.
    always_comb begin
        mem_awaddr  = lsu_awaddr;
        mem_wdata   = lsu_wdata;
        mem_wstrb   = lsu_wstrb;
        lsu_bresp   = mem_bresp;
        mem_awvalid = wr_active && lsu_awvalid && !aw_done_reg;
        lsu_awready = wr_active && mem_awready && !aw_done_reg;
        mem_wvalid  = wr_active && lsu_wvalid && !w_done_reg;
        lsu_wready  = wr_active && mem_wready && !w_done_reg;
        mem_bready  = wr_active && lsu_bready;
        lsu_bvalid  = wr_active && mem_bvalid;
    end

    assign ar_fire = mem_arvalid && mem_arready;
    assign r_fire  = mem_rvalid && mem_rready;
    assign aw_fire = mem_awvalid && mem_awready;
    assign w_fire  = mem_wvalid && mem_wready;
    assign b_fire  = mem_bvalid && mem_bready;

    // Next-state logic: arbitration in IDLE, completion tracking elsewhere.
    always_comb begin
        state_next   = state_reg;
        ar_done_next = ar_done_reg;
        aw_done_next = aw_done_reg;
        w_done_next  = w_done_reg;
        rr_lsu_next  = rr_lsu_reg;

        case (state_reg)
            IDLE: begin
                ar_done_next = 1'b0;
                aw_done_next = 1'b0;
                w_done_next  = 1'b0;
                // Writes win outright; reads share by round-robin.
                if (lsu_awvalid || lsu_wvalid) begin
                    state_next = WR_LSU;
                end else if (ifu_arvalid && lsu_arvalid) begin
                    state_next = rr_lsu_reg ? RD_LSU : RD_IFU;
                end else if (ifu_arvalid) begin
                    state_next = RD_IFU;
                end else if (lsu_arvalid) begin
                    state_next = RD_LSU;
                end
            end

            RD_IFU, RD_LSU: begin
                if (ar_fire) begin
                    ar_done_next = 1'b1;
                end
                if (r_fire) begin
                    state_next   = IDLE;
                    ar_done_next = 1'b0;
                    // Favour the other master at the next contention.
                    rr_lsu_next  = (state_reg == RD_IFU);
                end
            end

            WR_LSU: begin
                if (aw_fire) begin
                    aw_done_next = 1'b1;
                end
                if (w_fire) begin
                    w_done_next = 1'b1;
                end
                if (b_fire) begin
                    state_next   = IDLE;
                    aw_done_next = 1'b0;
                    w_done_next  = 1'b0;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_axi_arbiter.sv
// Testbench for axi_arbiter: directed master transactions against a small
// memory model; expected responses are queued at issue time and a negedge
// monitor pops and compares them as the DUT presents each response.
module tb_axi_arbiter;

    logic        clk;
    logic        rst;

    logic [31:0] ifu_araddr;
    logic        ifu_arvalid;
    logic        ifu_arready;
    logic [31:0] ifu_rdata;
    logic        ifu_rresp;
    logic        ifu_rvalid;
    logic        ifu_rready;

    logic [31:0] lsu_araddr;
    logic        lsu_arvalid;
    logic        lsu_arready;
    logic [31:0] lsu_rdata;
    logic        lsu_rresp;
    logic        lsu_rvalid;
    logic        lsu_rready;
    logic [31:0] lsu_awaddr;
    logic        lsu_awvalid;
    logic        lsu_awready;
    logic [31:0] lsu_wdata;
    logic [3:0]  lsu_wstrb;
    logic        lsu_wvalid;
    logic        lsu_wready;
    logic        lsu_bresp;
    logic        lsu_bvalid;
    logic        lsu_bready;

    logic [31:0] mem_araddr;
    logic        mem_arvalid;
    logic        mem_arready;
    logic [31:0] mem_rdata;
    logic        mem_rresp;
    logic        mem_rvalid;
    logic        mem_rready;
    logic [31:0] mem_awaddr;
    logic        mem_awvalid;
    logic        mem_awready;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_wvalid;
    logic        mem_wready;
    logic        mem_bresp;
    logic        mem_bvalid;
    logic        mem_bready;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [1:0]  kind;   // 0 = IFU read, 1 = LSU read, 2 = LSU write resp
        logic [31:0] data;
        logic        resp;
    } exp_t;

    exp_t exp_q[$];

    // Memory model state
    logic        bresp_val;
    int          mem_w_cnt;
    logic [31:0] cap_awaddr;
    logic [31:0] cap_wdata;
    logic [3:0]  cap_wstrb;

    logic [11:0] hs_outs;
    assign hs_outs = {ifu_arready, ifu_rvalid, lsu_arready, lsu_rvalid,
                      lsu_awready, lsu_wready, lsu_bvalid, mem_arvalid,
                      mem_rready, mem_awvalid, mem_wvalid, mem_bready};

    axi_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .ifu_araddr  (ifu_araddr),
        .ifu_arvalid (ifu_arvalid),
        .ifu_arready (ifu_arready),
        .ifu_rdata   (ifu_rdata),
        .ifu_rresp   (ifu_rresp),
        .ifu_rvalid  (ifu_rvalid),
        .ifu_rready  (ifu_rready),
        .lsu_araddr  (lsu_araddr),
        .lsu_arvalid (lsu_arvalid),
        .lsu_arready (lsu_arready),
        .lsu_rdata   (lsu_rdata),
        .lsu_rresp   (lsu_rresp),
        .lsu_rvalid  (lsu_rvalid),
        .lsu_rready  (lsu_rready),
        .lsu_awaddr  (lsu_awaddr),
        .lsu_awvalid (lsu_awvalid),
        .lsu_awready (lsu_awready),
        .lsu_wdata   (lsu_wdata),
        .lsu_wstrb   (lsu_wstrb),
        .lsu_wvalid  (lsu_wvalid),
        .lsu_wready  (lsu_wready),
        .lsu_bresp   (lsu_bresp),
        .lsu_bvalid  (lsu_bvalid),
        .lsu_bready  (lsu_bready),
        .mem_araddr  (mem_araddr),
        .mem_arvalid (mem_arvalid),
        .mem_arready (mem_arready),
        .mem_rdata   (mem_rdata),
        .mem_rresp   (mem_rresp),
        .mem_rvalid  (mem_rvalid),
        .mem_rready  (mem_rready),
        .mem_awaddr  (mem_awaddr),
        .mem_awvalid (mem_awvalid),
        .mem_awready (mem_awready),
        .mem_wdata   (mem_wdata),
        .mem_wstrb   (mem_wstrb),
        .mem_wvalid  (mem_wvalid),
        .mem_wready  (mem_wready),
        .mem_bresp   (mem_bresp),
        .mem_bvalid  (mem_bvalid),
        .mem_bready  (mem_bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic push_exp(input logic [1:0] k, input logic [31:0] d, input logic r);
        exp_t e;
        e.kind = k;
        e.data = d;
        e.resp = r;
        exp_q.push_back(e);
    endtask

    task automatic pop_cmp(input logic [1:0] k, input logic [31:0] d, input logic r);
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_resp: got kind=%0d data=%h resp=%0b, expected nothing", k, d, r);
        end else begin
            e = exp_q.pop_front();
            if (e.kind !== k || e.data !== d || e.resp !== r) begin
                errors++;
                $display("FAIL resp: got kind=%0d data=%h resp=%0b, expected kind=%0d data=%h resp=%0b",
                         k, d, r, e.kind, e.data, e.resp);
            end else begin
                $display("ok   resp kind=%0d data=%h resp=%0b", k, d, r);
            end
        end
    endtask

    // Response monitor: one pop per completed R or B handshake.
    always @(negedge clk) begin
        if (rst) begin
            if (ifu_rvalid && ifu_rready) pop_cmp(2'd0, ifu_rdata, ifu_rresp);
            if (lsu_rvalid && lsu_rready) pop_cmp(2'd1, lsu_rdata, lsu_rresp);
            if (lsu_bvalid && lsu_bready) pop_cmp(2'd2, 32'h0, lsu_bresp);
        end
    end

    function automatic logic [31:0] mem_lookup(input logic [31:0] a);
        case (a)
            32'h8000_0000: mem_lookup = 32'h0000_0413;
            32'h8000_0004: mem_lookup = 32'h0010_0093;
            32'h8000_1000: mem_lookup = 32'h1234_5678;
            32'h8000_2000: mem_lookup = 32'hCAFE_F00D;
            default:       mem_lookup = 32'h0;
        endcase
    endfunction

    // Memory model: handshakes sampled at negedge, responses updated just after posedge.
    initial begin
        bit ar_hs, r_hs, aw_hs, w_hs, b_hs, got_aw, got_w;
        logic [31:0] ar_a;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        mem_rresp  = 1'b0;
        mem_bvalid = 1'b0;
        mem_bresp  = 1'b0;
        mem_w_cnt  = 0;
        got_aw = 0;
        got_w  = 0;
        forever begin
            @(negedge clk);
            ar_hs = mem_arvalid && mem_arready;
            ar_a  = mem_araddr;
            r_hs  = mem_rvalid && mem_rready;
            aw_hs = mem_awvalid && mem_awready;
            w_hs  = mem_wvalid && mem_wready;
            b_hs  = mem_bvalid && mem_bready;
            if (aw_hs) cap_awaddr = mem_awaddr;
            if (w_hs) begin
                cap_wdata = mem_wdata;
                cap_wstrb = mem_wstrb;
            end
            @(posedge clk);
            #1;
            if (!rst) begin
                mem_rvalid = 1'b0;
                mem_bvalid = 1'b0;
                got_aw = 0;
                got_w  = 0;
            end else begin
                if (r_hs) mem_rvalid = 1'b0;
                if (ar_hs) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = mem_lookup(ar_a);
                end
                if (b_hs) mem_bvalid = 1'b0;
                if (aw_hs) got_aw = 1;
                if (w_hs) begin
                    got_w = 1;
                    mem_w_cnt++;
                end
                if (got_aw && got_w && !mem_bvalid) begin
                    mem_bvalid = 1'b1;
                    mem_bresp  = bresp_val;
                    got_aw = 0;
                    got_w  = 0;
                end
            end
        end
    end

    task automatic ifu_ar(input logic [31:0] a);
        bit done = 0;
        ifu_araddr  = a;
        ifu_arvalid = 1'b1;
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge clk);
            if (ifu_arready) done = 1;
            @(posedge clk);
            #1;
        end
        ifu_arvalid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL ifu_ar_timeout: got no arready, expected handshake for %h", a);
        end
    endtask

    task automatic lsu_ar(input logic [31:0] a);
        bit done = 0;
        lsu_araddr  = a;
        lsu_arvalid = 1'b1;
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge clk);
            if (lsu_arready) done = 1;
            @(posedge clk);
            #1;
        end
        lsu_arvalid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL lsu_ar_timeout: got no arready, expected handshake for %h", a);
        end
    endtask

    task automatic lsu_aw(input logic [31:0] a);
        bit done = 0;
        lsu_awaddr  = a;
        lsu_awvalid = 1'b1;
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge clk);
            if (lsu_awready) done = 1;
            @(posedge clk);
            #1;
        end
        lsu_awvalid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL lsu_aw_timeout: got no awready, expected handshake for %h", a);
        end
    endtask

    task automatic lsu_w(input logic [31:0] d, input logic [3:0] s);
        bit done = 0;
        lsu_wdata  = d;
        lsu_wstrb  = s;
        lsu_wvalid = 1'b1;
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge clk);
            if (lsu_wready) done = 1;
            @(posedge clk);
            #1;
        end
        lsu_wvalid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL lsu_w_timeout: got no wready, expected handshake for %h", d);
        end
    endtask

    task automatic lsu_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        fork
            lsu_aw(a);
            lsu_w(d, s);
        join
    endtask

    // Wait until every queued response has been seen, then realign after posedge.
    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_drain: got %0d responses outstanding, expected 0", name, exp_q.size());
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst         = 1'b0;
        ifu_araddr  = 32'h0;
        ifu_arvalid = 1'b0;
        ifu_rready  = 1'b1;
        lsu_araddr  = 32'h0;
        lsu_arvalid = 1'b0;
        lsu_rready  = 1'b1;
        lsu_awaddr  = 32'h0;
        lsu_awvalid = 1'b0;
        lsu_wdata   = 32'h0;
        lsu_wstrb   = 4'h0;
        lsu_wvalid  = 1'b0;
        lsu_bready  = 1'b1;
        mem_arready = 1'b1;
        mem_awready = 1'b1;
        mem_wready  = 1'b1;
        bresp_val   = 1'b0;

        // Reset state: every handshake output low.
        #1;
        chk("reset_outs_zero", 32'(hs_outs), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // IFU read alone, with grant latency through one IDLE cycle.
        push_exp(2'd0, 32'h0000_0413, 1'b0);
        fork
            ifu_ar(32'h8000_0000);
            begin
                @(negedge clk);
                chk("grant_idle_cycle_arvalid", 32'(mem_arvalid), 32'h0);
                @(negedge clk);
                chk("grant_arvalid", 32'(mem_arvalid), 32'h1);
                chk("grant_araddr", mem_araddr, 32'h8000_0000);
            end
        join
        wait_drain("ifu_alone");
        @(negedge clk);
        chk("idle_after_ifu", 32'(hs_outs), 32'h0);

        // Fresh reset: contention goes to the IFU first, then LSU.
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        push_exp(2'd0, 32'h0000_0413, 1'b0);
        push_exp(2'd1, 32'h1234_5678, 1'b0);
        fork
            ifu_ar(32'h8000_0000);
            lsu_ar(32'h8000_1000);
        join
        wait_drain("rr_ifu_first");

        // After an IFU grant, contention goes to the LSU.
        push_exp(2'd0, 32'h0010_0093, 1'b0);
        ifu_ar(32'h8000_0004);
        wait_drain("ifu_single");
        push_exp(2'd1, 32'hCAFE_F00D, 1'b0);
        push_exp(2'd0, 32'h0000_0413, 1'b0);
        fork
            ifu_ar(32'h8000_0000);
            lsu_ar(32'h8000_2000);
        join
        wait_drain("rr_lsu_first");

        // Write beats a simultaneous IFU read.
        bresp_val = 1'b0;
        push_exp(2'd2, 32'h0, 1'b0);
        push_exp(2'd0, 32'h0000_0413, 1'b0);
        fork
            lsu_write(32'h8000_0100, 32'hDEAD_BEEF, 4'hF);
            ifu_ar(32'h8000_0000);
        join
        wait_drain("wr_vs_rd");
        chk("wr_awaddr", cap_awaddr, 32'h8000_0100);
        chk("wr_wdata", cap_wdata, 32'hDEAD_BEEF);
        chk("wr_wstrb", 32'(cap_wstrb), 32'hF);

        // W accepted two cycles before AW: one W beat, one B.
        begin
            int w0;
            w0 = mem_w_cnt;
            bresp_val   = 1'b1;
            mem_awready = 1'b0;
            push_exp(2'd2, 32'h0, 1'b1);
            fork
                lsu_write(32'h8000_0200, 32'h0BAD_F00D, 4'h3);
                begin
                    repeat (3) @(posedge clk);
                    #1;
                    mem_awready = 1'b1;
                end
            join
            wait_drain("w_before_aw");
            chk("w_before_aw_wbeats", 32'(mem_w_cnt - w0), 32'h1);
            chk("w_before_aw_awaddr", cap_awaddr, 32'h8000_0200);
            chk("w_before_aw_wstrb", 32'(cap_wstrb), 32'h3);
            bresp_val = 1'b0;
        end

        // IFU read backpressure with a pending LSU read.
        ifu_rready = 1'b0;
        push_exp(2'd0, 32'h0010_0093, 1'b0);
        push_exp(2'd1, 32'h1234_5678, 1'b0);
        fork
            ifu_ar(32'h8000_0004);
            begin
                @(posedge clk);
                #1;
                lsu_ar(32'h8000_1000);
            end
            begin
                int n = 0;
                @(negedge clk);
                while (!ifu_rvalid && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                for (int c = 0; c < 3; c++) begin
                    if (c != 0) @(negedge clk);
                    chk("bp_ifu_rvalid", 32'(ifu_rvalid), 32'h1);
                    chk("bp_lsu_arready", 32'(lsu_arready), 32'h0);
                    chk("bp_mem_arvalid", 32'(mem_arvalid), 32'h0);
                end
                @(posedge clk);
                #1;
                ifu_rready = 1'b1;
            end
        join
        wait_drain("backpressure");

        // Reset in the middle of an LSU read, then a normal IFU read.
        lsu_rready = 1'b0;
        lsu_ar(32'h8000_2000);
        @(negedge clk);
        chk("rd_lsu_pending_rvalid", 32'(lsu_rvalid), 32'h1);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("reset_mid_read_outs", 32'(hs_outs), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        lsu_rready = 1'b1;
        rst = 1'b1;
        push_exp(2'd0, 32'h0010_0093, 1'b0);
        ifu_ar(32'h8000_0004);
        wait_drain("after_reset");
        @(negedge clk);
        chk("final_idle_outs", 32'(hs_outs), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/axi_arbiter.md
AXI_ARBITER -- requirements
Module: axi_arbiter

Interface
REQ-001 SHALL have no parameters; all addresses/data 32 bits, wstrb 4 bits, resp 1 bit.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have IFU read-address ports: ifu_araddr in 32, ifu_arvalid in 1, ifu_arready out 1.
REQ-005 SHALL have IFU read-data ports: ifu_rdata out 32, ifu_rresp out 1, ifu_rvalid out 1, ifu_rready in 1.
REQ-006 SHALL have LSU read-address ports: lsu_araddr in 32, lsu_arvalid in 1, lsu_arready out 1.
REQ-007 SHALL have LSU read-data ports: lsu_rdata out 32, lsu_rresp out 1, lsu_rvalid out 1, lsu_rready in 1.
REQ-008 SHALL have LSU write-address ports: lsu_awaddr in 32, lsu_awvalid in 1, lsu_awready out 1.
REQ-009 SHALL have LSU write-data ports: lsu_wdata in 32, lsu_wstrb in 4, lsu_wvalid in 1, lsu_wready out 1.
REQ-010 SHALL have LSU write-response ports: lsu_bresp out 1, lsu_bvalid out 1, lsu_bready in 1.
REQ-011 SHALL have memory-side ports mirroring all five channels, prefixed mem_ (araddr/arvalid out, arready in; rdata/rresp/rvalid in, rready out; awaddr/awvalid out, awready in; wdata/wstrb/wvalid out, wready in; bresp/bvalid in, bready out).

Function
REQ-012 SHALL implement FSM states IDLE, RD_IFU, RD_LSU, WR_LSU; exactly one transaction outstanding on the memory side.
REQ-013 SHALL in IDLE drive all mem_*valid, mem_rready, mem_bready and all master-side ready/valid outputs to 0.
REQ-014 SHALL in IDLE pick next state from registered requests: lsu_awvalid|lsu_wvalid -> WR_LSU (highest priority); else arvalid contention resolved round-robin, IFU winning after an LSU read grant and LSU winning after an IFU read grant; lone requester wins.
REQ-015 SHALL spend exactly one IDLE cycle between transactions (grant decision registered; no same-cycle pass-through from IDLE).
REQ-016 SHALL in RD_x route granted master's araddr/arvalid to mem, mem_arready to that master's arready, mem rdata/rresp/rvalid to that master, master rready to mem_rready.
REQ-017 SHALL set flag ar_done on mem AR handshake and thereafter force mem_arvalid=0 and master arready=0 until state exit.
REQ-018 SHALL leave RD_x to IDLE on the cycle after mem_rvalid & rready; update round-robin pointer on that exit.
REQ-019 SHALL in WR_LSU route AW, W, B channels between LSU and mem; aw_done and w_done flags independently suppress re-issue after their handshakes, in either order or same cycle.
REQ-020 SHALL leave WR_LSU to IDLE after mem_bvalid & lsu_bready; round-robin pointer unchanged by writes.
REQ-021 SHALL hold the non-granted master's ready/valid outputs at 0 for the whole transaction; its requests remain pending, never dropped.
REQ-022 SHALL pass rdata, rresp, bresp combinationally (zero added data latency); grant-to-mem-arvalid latency one cycle after request first seen in IDLE.
REQ-023 SHALL treat a master deasserting valid before handshake as protocol violation; behaviour undefined, no recovery required.

Reset
REQ-024 SHALL on rst=0 asynchronously enter IDLE, clear ar_done/aw_done/w_done, set round-robin pointer to favour IFU, so all valid/ready outputs read 0.
REQ-025 SHALL, if reset asserts mid-transaction, abandon it; memory side sees valid/ready drop immediately, no response forwarded after release.
REQ-026 SHALL resume arbitration first rising edge after rst returns to 1.

Verification
REQ-027 IFU read alone: ifu_araddr=0x80000000 held valid, mem returns rdata=0x00000413 next cycle -> ifu_rvalid=1, ifu_rdata=0x00000413, lsu_rvalid=0, FSM back to IDLE.
REQ-028 Simultaneous IFU/LSU reads after reset: IFU granted first, LSU (0x80001000) served after one IDLE cycle; repeat with both -> LSU granted first (round-robin).
REQ-029 LSU write vs IFU read same cycle: awaddr=0x80000100, wdata=0xDEADBEEF, wstrb=0xF -> mem sees write first, lsu_bvalid=1, then IFU read granted.
REQ-030 Write channel ordering: W handshake two cycles before AW -> single mem_wvalid pulse accepted, no duplicate, B forwarded once.
REQ-031 Backpressure: ifu_rready=0 for 3 cycles with mem_rvalid=1 -> state stays RD_IFU, LSU arready stays 0, completes when rready=1.
REQ-032 Reset mid-read: rst=0 while in RD_LSU -> all outputs 0 same cycle, after release an IFU read proceeds normally.
